// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared definitions for the 3-input gate sweep controller: state encoding,
// reference function codes and the gate delay used by the lab gate library.
`ifndef GATE_DELAY
`define GATE_DELAY 15
`endif

package gate_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

    localparam logic [1:0] FUNC_AND  = 2'b00;
    localparam logic [1:0] FUNC_OR   = 2'b01;
    localparam logic [1:0] FUNC_NAND = 2'b10;
    localparam logic [1:0] FUNC_NOR  = 2'b11;

    localparam logic [2:0] LAST_VEC = 3'd7;

endpackage

// File: rtl/gate_sweep_ctrl_ref_model.sv
// Combinational golden model of the 3-input gate selected by func.
module gate_ref_model
    import gate_sweep_ctrl_pkg::*;
(
    input  logic [1:0] func,
    input  logic [2:0] vec,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (func)
            FUNC_AND:  expected = &vec;
            FUNC_OR:   expected = |vec;
            FUNC_NAND: expected = ~&vec;
            FUNC_NOR:  expected = ~|vec;
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all eight input vectors through an external 3-input gate, waits a
// settle time per vector, and scores each sample against a reference gate.
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       func_sel,
    input  logic             gate_out,
    output logic [2:0]       gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       fail_vec,
    output logic             fail_valid
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    sweep_state_t    state;
    sweep_state_t    state_next;
    logic [2:0]      vec;
    logic [SC_W-1:0] settle_cnt;
    logic [1:0]      func_q;
    logic            expected;
    logic            mismatch;

    gate_ref_model u_ref (
        .func     (func_q),
        .vec      (gate_in),
        .expected (expected)
    );

    // Identity comparison so an undriven or unknown gate output scores as an error.
    assign mismatch = (gate_out !== expected);

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_APPLY;
            ST_APPLY:  state_next = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (vec == LAST_VEC) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    // Abort only parks the vector; the partial score stays visible for debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_in    <= '0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
            vec        <= '0;
            settle_cnt <= '0;
            func_q     <= FUNC_AND;
        end else if (state == ST_IDLE) begin
            if (start) begin
                func_q     <= func_sel;
                vec        <= '0;
                err_cnt    <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= '0;
                pass       <= 1'b0;
            end
        end else if (abort) begin
            gate_in <= '0;
        end else begin
            case (state)
                ST_APPLY: begin
                    gate_in    <= vec;
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        if (err_cnt != ERR_MAX) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        if (!fail_valid) begin
                            fail_vec   <= gate_in;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (vec != LAST_VEC) begin
                        vec <= vec + 3'd1;
                    end
                end
                ST_DONE: begin
                    pass <= (err_cnt == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
